enc_rr_arbiter: RTL and testbench
=================================

# enc_rr_arbiter

- Round-robin arbiter for seven requesters that share one 3-bit code resource. Index 0 means "no grant".
- Grants exactly one requester at a time. The granted index is presented in three registered forms:
  - binary,
  - gray (same table as the gray encoder: 0→000, 1→001, 2→011, 3→010, 4→110, 5→111, 6→101, 7→100),
  - one-hot (same table as the hot encoder: idx k → bit k-1, idx 0 → all zeros).
- Sits in front of the gray/one-hot encoder datapath and sequences which client drives it.

## Interface
Parameters:
- MAX_HOLD, default 15 — maximum consecutive GRANT cycles per grant when the timeout feature is compiled in; legal range 1..255.

Ports:
- clk  in  1 — single clock, rising edge.
- rst_n  in  1 — asynchronous, active-low reset.
- req  in  7 — level request; bit k-1 belongs to requester index k (1..7).
- gnt_idx  out  3 — granted index, binary; 0 = none.
- gnt_gray  out  3 — gray code of gnt_idx.
- gnt_onehot  out  7 — one-hot of gnt_idx; all zeros when none.
- busy  out  1 — high while in GRANT.
- timeout  out  1 — one-cycle pulse on forced revoke. Tied 0 when the feature is compiled out.

## Operation
- States: IDLE, GRANT. Reset state is IDLE.
- Round-robin pointer `last` (3 bits) resets to 7.

IDLE:
- If req == 0, stay in IDLE.
- Otherwise pick the first set requester searching last+1, last+2, … with wrap 7→1 (index 0 is never searched).
- Load all grant outputs with the pick, set last = pick, go to GRANT.

GRANT:
- Requester holds its req bit high while it uses the resource.
- When req[gnt_idx-1] is sampled low → IDLE; all grant outputs go to 0.
- Requests from other requesters are ignored while in GRANT.

Encoding:
- gnt_gray and gnt_onehot are derived from the next-state index and registered together with gnt_idx.
- The three outputs are never mutually inconsistent in any cycle.

Reset mid-grant:
- All outputs go to 0 immediately (asynchronous).
- last = 7 and the hold counter clears.

## Timing
Reset values: gnt_idx 000, gnt_gray 000, gnt_onehot 0000000, busy 0, timeout 0.

Grant latency:
- req is sampled at edge n while in IDLE.
- Grant outputs are valid after edge n, i.e. during cycle n+1.

Release:
- A req drop sampled at edge m clears the outputs after edge m.
- The next grant appears no earlier than after edge m+1, so there is always one IDLE cycle between grants.

Fairness:
- With all seven requesting and each releasing after one GRANT cycle, the grant order is 1,2,…,7,1.
- Each grant is separated by one idle cycle.

## Configuration
- Macro: ENC_ARB_TIMEOUT_EN.

Defined:
- An 8-bit hold counter loads 1 on entry to GRANT and increments each GRANT cycle.
- If the counter equals MAX_HOLD and req[gnt_idx-1] is still high at an edge, the grant is revoked:
  - go to IDLE, outputs clear,
  - timeout is high for exactly that following cycle,
  - last keeps the revoked index, so that requester has the lowest priority at re-arbitration.
- If the release and the MAX_HOLD limit occur at the same edge, it is treated as a normal release (no timeout pulse).

Undefined:
- No counter is present; a grant lasts indefinitely.
- timeout is constant 0 and MAX_HOLD is ignored.

## Structure
Shared package `enc_arb_pkg` holds:
- state enum {IDLE, GRANT},
- constant GRAY_LUT[8] (3-bit entries),
- constant ONEHOT_LUT[8] (7-bit entries),
- the requester count constant, 7.

Sub-module `rr_pick`:
- Combinational.
- Inputs: req[6:0], last[2:0].
- Outputs: pick[2:0] and pick_valid.
- Implements the rotate-and-priority search.

The top level holds the FSM, pointer, hold counter and output registers.

## Test plan
1. Reset, then req=0000100 held → after 2 edges gnt_idx=3, gnt_gray=010, gnt_onehot=0000100, busy=1; drop req → outputs return to 0 the next cycle.
2. req=1111111 with each requester releasing after one GRANT cycle → gnt_idx sequence 1,2,3,4,5,6,7,1, separated by idle cycles; gray sequence 001,011,010,110,111,101,100,001.
3. Granted to 5 with req=0010001 held; 5 releases → next grant is 1, not 5, even though 5's req returns high; wrap from 7 → 1 verified.
4. rst_n pulled low mid-GRANT (idx 6) → outputs 0 in the same cycle without a clock edge; after release with req=1000000 → grant 7 (search starts at 1, only 7 requesting).
5. ENC_ARB_TIMEOUT_EN, MAX_HOLD=4, req=0000010 held forever → gnt_idx=2 for exactly 4 cycles, then timeout=1 for one cycle with outputs 0, then regrant 2 after the next edge.
6. ENC_ARB_TIMEOUT_EN, MAX_HOLD=4, release sampled on the 4th GRANT edge → no timeout pulse; normal IDLE entry.

Source files
------------

// File: rtl/enc_arb_pkg.sv
// Shared types and code tables for the round-robin encoder arbiter.
// Tables match the downstream gray / one-hot encoders so grant outputs line up with them.
package enc_arb_pkg;

    localparam int NUM_REQ = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [2:0] GRAY_LUT [8] = '{
        3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100
    };

    localparam logic [6:0] ONEHOT_LUT [8] = '{
        7'b0000000, 7'b0000001, 7'b0000010, 7'b0000100,
        7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000
    };

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first set requester after 'last', wrapping 7 -> 1.
// Index 0 is never a candidate; pick is 0 when nobody requests.
module rr_pick
    import enc_arb_pkg::*;
(
    input  logic [6:0] req,
    input  logic [2:0] last,
    output logic [2:0] pick,
    output logic       pick_valid
);

    logic [3:0] cand;
    logic [2:0] cand3;

    // Scan from farthest to nearest so the nearest hit overwrites the others.
    always_comb begin
        pick       = 3'd0;
        pick_valid = 1'b0;
        cand       = 4'd0;
        cand3      = 3'd0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, last} + 4'(i);
            if (cand > 4'd7) begin
                cand = cand - 4'd7;
            end
            cand3 = cand[2:0];
            if (req[cand3 - 3'd1]) begin
                pick       = cand3;
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enc_rr_arbiter.sv
// Seven-way round-robin arbiter with registered binary, gray and one-hot grant outputs.
// Optional hold-time revoke is compiled in with ENC_ARB_TIMEOUT_EN.
module enc_rr_arbiter
    import enc_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] req,
    output logic [2:0] gnt_idx,
    output logic [2:0] gnt_gray,
    output logic [6:0] gnt_onehot,
    output logic       busy,
    output logic       timeout
);

    state_t     state;
    logic [2:0] last;
    logic [2:0] pick;
    logic       pick_valid;
    logic       held;

    rr_pick u_rr_pick (
        .req        (req),
        .last       (last),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    // Only meaningful in GRANT, where gnt_idx is never 0.
    assign held = req[gnt_idx - 3'd1];

`ifdef ENC_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= 3'd7;
            gnt_idx    <= 3'd0;
            gnt_gray   <= 3'd0;
            gnt_onehot <= 7'd0;
            busy       <= 1'b0;
`ifdef ENC_ARB_TIMEOUT_EN
            hold_cnt   <= 8'd0;
            timeout    <= 1'b0;
`endif
        end else begin
`ifdef ENC_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= GRANT;
                        last       <= pick;
                        gnt_idx    <= pick;
                        gnt_gray   <= GRAY_LUT[pick];
                        gnt_onehot <= ONEHOT_LUT[pick];
                        busy       <= 1'b1;
`ifdef ENC_ARB_TIMEOUT_EN
                        hold_cnt   <= 8'd1;
`endif
                    end
                end
                GRANT: begin
                    if (!held) begin
                        state      <= IDLE;
                        gnt_idx    <= 3'd0;
                        gnt_gray   <= 3'd0;
                        gnt_onehot <= 7'd0;
                        busy       <= 1'b0;
`ifdef ENC_ARB_TIMEOUT_EN
                        hold_cnt   <= 8'd0;
                    end else if (hold_cnt == 8'(MAX_HOLD)) begin
                        // Revoked requester stays in 'last', so it ranks lowest next round.
                        state      <= IDLE;
                        gnt_idx    <= 3'd0;
                        gnt_gray   <= 3'd0;
                        gnt_onehot <= 7'd0;
                        busy       <= 1'b0;
                        hold_cnt   <= 8'd0;
                        timeout    <= 1'b1;
                    end else begin
                        hold_cnt   <= hold_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enc_rr_arbiter.sv
// Directed bench for enc_rr_arbiter; timeout scenarios depend on ENC_ARB_TIMEOUT_EN.
module tb_enc_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [6:0] req;
    logic [2:0] gnt_idx;
    logic [2:0] gnt_gray;
    logic [6:0] gnt_onehot;
    logic       busy;
    logic       timeout;

    int vectors;
    int miscompares;

    logic [2:0] seq_idx  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    logic [2:0] seq_gray [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b001};
    logic [6:0] seq_oh   [8] = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000,
                                 7'b0010000, 7'b0100000, 7'b1000000, 7'b0000001};

    enc_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt_idx    (gnt_idx),
        .gnt_gray   (gnt_gray),
        .gnt_onehot (gnt_onehot),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_idx, input logic [2:0] e_gray,
                           input logic [6:0] e_oh, input logic e_busy, input logic e_to);
        chk_val({tag, ".idx"},     {5'd0, gnt_idx},    {5'd0, e_idx});
        chk_val({tag, ".gray"},    {5'd0, gnt_gray},   {5'd0, e_gray});
        chk_val({tag, ".onehot"},  {1'b0, gnt_onehot}, {1'b0, e_oh});
        chk_val({tag, ".busy"},    {7'd0, busy},       {7'd0, e_busy});
        chk_val({tag, ".timeout"}, {7'd0, timeout},    {7'd0, e_to});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 7'd0;
        #1;
        chk_out("reset", 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req         = 7'd0;
        #1;
        chk_out("por", 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;

        // Single requester 3: grant one edge after sampling, clear one edge after release.
        req = 7'b0000100;
        step();
        chk_out("t1.grant", 3'd3, 3'b010, 7'b0000100, 1'b1, 1'b0);
        step();
        chk_out("t1.hold", 3'd3, 3'b010, 7'b0000100, 1'b1, 1'b0);
        req = 7'b0000000;
        step();
        chk_out("t1.release", 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b0);

        // All requesting, each releasing after one GRANT cycle.
        do_reset();
        req = 7'b1111111;
        for (int j = 0; j < 8; j++) begin
            step();
            chk_out($sformatf("t2.grant%0d", j), seq_idx[j], seq_gray[j], seq_oh[j], 1'b1, 1'b0);
            req = 7'b1111111 & ~seq_oh[j];
            step();
            chk_out($sformatf("t2.idle%0d", j), 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b0);
            req = 7'b1111111;
        end

        // Released requester 5 loses to 1 even when it re-requests.
        do_reset();
        req = 7'b0010000;
        step();
        chk_out("t3.grant5", 3'd5, 3'b111, 7'b0010000, 1'b1, 1'b0);
        req = 7'b0010001;
        step();
        chk_out("t3.ignore1", 3'd5, 3'b111, 7'b0010000, 1'b1, 1'b0);
        req = 7'b0000001;
        step();
        chk_out("t3.rel5", 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b0);
        req = 7'b0010001;
        step();
        chk_out("t3.grant1", 3'd1, 3'b001, 7'b0000001, 1'b1, 1'b0);

        // Wrap 7 -> 1.
        do_reset();
        req = 7'b1000000;
        step();
        chk_out("t3.grant7", 3'd7, 3'b100, 7'b1000000, 1'b1, 1'b0);
        req = 7'b1000001;
        step();
        chk_out("t3.hold7", 3'd7, 3'b100, 7'b1000000, 1'b1, 1'b0);
        req = 7'b0000001;
        step();
        chk_out("t3.rel7", 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b0);
        req = 7'b1000001;
        step();
        chk_out("t3.wrap1", 3'd1, 3'b001, 7'b0000001, 1'b1, 1'b0);

        // Asynchronous reset mid-grant of 6.
        do_reset();
        req = 7'b0100000;
        step();
        chk_out("t4.grant6", 3'd6, 3'b101, 7'b0100000, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t4.async", 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b0);
        req = 7'b1000000;
        step();
        rst_n = 1'b1;
        step();
        chk_out("t4.grant7", 3'd7, 3'b100, 7'b1000000, 1'b1, 1'b0);

        // Pointer returns to 7 on reset: with 6 and 7 requesting, 6 wins.
        req = 7'b0000000;
        step();
        req = 7'b0100000;
        step();
        chk_out("t4b.grant6", 3'd6, 3'b101, 7'b0100000, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        req = 7'b1100000;
        step();
        rst_n = 1'b1;
        step();
        chk_out("t4b.ptr", 3'd6, 3'b101, 7'b0100000, 1'b1, 1'b0);

`ifdef ENC_ARB_TIMEOUT_EN
        // Held forever: 4 GRANT cycles, one timeout cycle, then regrant.
        do_reset();
        req = 7'b0000010;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk_out($sformatf("t5.hold%0d", c), 3'd2, 3'b011, 7'b0000010, 1'b1, 1'b0);
        end
        step();
        chk_out("t5.timeout", 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b1);
        step();
        chk_out("t5.regrant", 3'd2, 3'b011, 7'b0000010, 1'b1, 1'b0);

        // Release coinciding with the hold limit is a plain release.
        do_reset();
        req = 7'b0000010;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk_out($sformatf("t6.hold%0d", c), 3'd2, 3'b011, 7'b0000010, 1'b1, 1'b0);
        end
        req = 7'b0000000;
        step();
        chk_out("t6.release", 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b0);
        step();
        chk_out("t6.idle", 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b0);
`else
        // Without the timeout feature a grant persists well past MAX_HOLD.
        do_reset();
        req = 7'b0000010;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk_out($sformatf("t5.hold%0d", c), 3'd2, 3'b011, 7'b0000010, 1'b1, 1'b0);
        end
        req = 7'b0000000;
        step();
        chk_out("t5.release", 3'd0, 3'b000, 7'b0000000, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
